alu_seq: RTL
============

# alu_seq

Operand-issue and result-retire sequencer wrapped around the combinational/pipelined `alu` in the Zet execution stage.
- Upstream: registers an ALU request from the decoder/microcode.
- Downstream of the ALU: holds the ALU inputs stable for the operation's latency, then captures `out`/`oflags`/`div_exc`.
- Owns the architectural FLAGS register, which drives the ALU's `iflags`.
- Reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- MUL_LAT, 3, cycles alu inputs are held before sampling a multiply (t==3, func[1]==0); minimum 1.
- DIV_LAT, 34, cycles held before sampling a divide (t==3, func[1]==1); minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  request present.
- issue_ready  out  1  sequencer idle, request will be taken.
- issue_x  in  32  operand x.
- issue_y  in  16  operand y.
- issue_t  in  3  ALU unit select.
- issue_func  in  3  ALU function.
- issue_word  in  1  word_op.
- issue_seg  in  16  segment.
- issue_off  in  16  offset.
- issue_fen  in  1  operation writes FLAGS.
- flags_ld  in  1  load FLAGS from flags_in (popf/iret).
- flags_in  in  16  value for flags_ld.
- alu_x, alu_y, alu_t, alu_func, alu_word_op, alu_seg, alu_off  out  32/16/3/3/1/16/16  registered copies to alu.
- alu_iflags  out  16  equals the FLAGS register.
- alu_out  in  32  alu result.
- alu_oflags  in  9  alu flags {of,df,if,tf,sf,zf,af,pf,cf}.
- alu_div_exc  in  1  alu divide exception.
- res  out  32  retired result.
- flags  out  16  FLAGS register.
- done  out  1  one-cycle retire pulse.
- exc  out  1  one-cycle divide-error pulse, coincident with done.

## Operation
**States**
- IDLE: `issue_ready`=1.
  - On `issue_valid`: register all `issue_*` fields into `alu_*` and `fen`.
  - Load `cnt` with lat−1, where lat = DIV_LAT for t==3 & func[1], MUL_LAT for t==3 & !func[1], and 1 otherwise.
  - Go to BUSY.
- BUSY: `issue_ready`=0; `alu_*` held constant.
  - If `cnt`≠0, decrement.
  - If `cnt`==0, retire at this edge and go to IDLE.

**Retire, no exception**
- `res` ← `alu_out`.
- If `fen`, merge `alu_oflags` into FLAGS bits {11,10,9,8,7,6,4,2,0}.
- `done` ← 1.

**Retire, divide op with `alu_div_exc`=1**
- `res` and FLAGS unchanged.
- `done` ← 1, `exc` ← 1.
- `alu_div_exc` is ignored for all non-divide ops.

**FLAGS register**
- Bit 1 is forced to 1; bits 5 and 3 are forced to 0.
- Bits 15:12 change only via `flags_ld`.
- `flags_ld` is honoured only in IDLE.
  - It takes effect at that edge, even if an issue is accepted on the same edge.
  - The issued op then sees the loaded value on `alu_iflags` from the next cycle.
- `flags_ld` during BUSY is ignored; the requester must hold it until `issue_ready`.

**Reset values**
- State IDLE.
- `issue_ready`=1 in the cycle after reset.
- `done`=0, `exc`=0, `res`=0, every `alu_*`=0.
- FLAGS=16'h0002.

**Reset mid-operation**
- Abandon the op; no `done` is produced; all of the above values apply.

## Timing
- Issue accepted at edge k. `alu_*` are valid from cycle k+1.
- Retire sampling edge is k+lat; `done`/`exc`/`res`/FLAGS are visible in cycle k+lat+1.
- `issue_ready` is 1 again in cycle k+lat+1, so the next issue can be accepted at edge k+lat+1.
- Maximum throughput is one op per lat+1 cycles.
- `done` and `exc` are high for exactly one cycle. `res` is held until the next retire.
- `alu_iflags` is combinational from the FLAGS register.

## Configuration
- ALU_DIV_EN defined: divides wait DIV_LAT cycles and retire as above.
- ALU_DIV_EN undefined:
  - Divides use lat=1 and always retire with `exc`=1.
  - `res` and FLAGS are unchanged; `alu_div_exc` is ignored.
  - DIV_LAT is unused.
- Multiplies are unaffected in both cases.

## Test plan
- ADD (t=1, func=0, word, x=0x7FFF, y=1, fen=1), FLAGS=0x0002:
  - `done` 2 cycles after the issue edge; `res`=0x8000.
  - FLAGS of=1, sf=1, zf=0, af=1, pf=1, cf=0, so FLAGS=0x0896.
- Unsigned multiply (t=3, func=0, word, x=0xFFFF, y=0xFFFF), MUL_LAT=3:
  - `issue_ready`=0 for 3 cycles; `alu_*` stable throughout.
  - `done` at k+4; `res`=0xFFFE0001; cf=of=1.
- Divide x=0x0001_0000 by y=0 with ALU_DIV_EN defined:
  - `done`=`exc`=1 at k+DIV_LAT+1.
  - `res` and FLAGS unchanged from their prior values.
- Same divide with ALU_DIV_EN undefined:
  - `done`=`exc`=1 at k+2.
- `flags_ld` with `flags_in`=0xFFFF in IDLE, together with an issue (t=4, func=0, fen=0):
  - FLAGS=0xFFD7; `alu_iflags`=0xFFD7 from k+1.
  - FLAGS unchanged at retire because fen=0.
  - A `flags_ld` pulsed while BUSY is ignored.
- `rst` asserted 5 cycles into a divide:
  - No `done` pulse.
  - Next cycle: `issue_ready`=1, FLAGS=0x0002, `res`=0, `alu_t`=0.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - ALU issue/retire sequencer owning FLAGS; ALU_DIV_EN enables real divides
module alu_seq #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [31:0] issue_x,
   input  logic [15:0] issue_y,
   input  logic [2:0]  issue_t,
   input  logic [2:0]  issue_func,
   input  logic        issue_word,
   input  logic [15:0] issue_seg,
   input  logic [15:0] issue_off,
   input  logic        issue_fen,
   input  logic        flags_ld,
   input  logic [15:0] flags_in,
   output logic [31:0] alu_x,
   output logic [15:0] alu_y,
   output logic [2:0]  alu_t,
   output logic [2:0]  alu_func,
   output logic        alu_word_op,
   output logic [15:0] alu_seg,
   output logic [15:0] alu_off,
   output logic [15:0] alu_iflags,
   input  logic [31:0] alu_out,
   input  logic [8:0]  alu_oflags,
   input  logic        alu_div_exc,
   output logic [31:0] res,
   output logic [15:0] flags,
   output logic        done,
   output logic        exc
);
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      alu_x_q, res_q;
   logic [15:0]      alu_y_q, alu_seg_q, alu_off_q, flags_q;
   logic [2:0]       alu_t_q, alu_func_q;
   logic             alu_word_q, fen_q, done_q, exc_q;
   logic [15:0]      flags_ld_d, flags_ret_d;
   logic             is_div_d, ret_exc_d;

   // Initial countdown for the incoming request: lat-1 busy cycles beyond the first
   always_comb begin
      cnt_d = '0;
      if (issue_t == 3'd3 && !issue_func[1]) begin
         cnt_d = CNT_W'(MUL_LAT - 1);
      end
`ifdef ALU_DIV_EN
      else if (issue_t == 3'd3 && issue_func[1]) begin
         cnt_d = CNT_W'(DIV_LAT - 1);
      end
`endif
   end

   // FLAGS next values: bit 1 stuck at 1, bits 5 and 3 stuck at 0, ALU never touches 15:12
   always_comb begin
      flags_ld_d      = (flags_in & 16'hFFD7) | 16'h0002;
      flags_ret_d     = flags_q;
      flags_ret_d[11:6] = alu_oflags[8:3];
      flags_ret_d[4]  = alu_oflags[2];
      flags_ret_d[2]  = alu_oflags[1];
      flags_ret_d[0]  = alu_oflags[0];
   end

   // Divide detection on the held operation; without real divide support every divide faults
   always_comb begin
      is_div_d = (alu_t_q == 3'd3) && alu_func_q[1];
`ifdef ALU_DIV_EN
      ret_exc_d = is_div_d && alu_div_exc;
`else
      ret_exc_d = is_div_d;
`endif
   end

`ifndef ALU_DIV_EN
   logic div_exc_unused;
   assign div_exc_unused = alu_div_exc;
`endif

   // Sequencer FSM: accept in IDLE, hold operands while BUSY, retire when the count expires
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         alu_x_q    <= '0;
         alu_y_q    <= '0;
         alu_t_q    <= '0;
         alu_func_q <= '0;
         alu_word_q <= 1'b0;
         alu_seg_q  <= '0;
         alu_off_q  <= '0;
         fen_q      <= 1'b0;
         flags_q    <= 16'h0002;
         res_q      <= '0;
         done_q     <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         exc_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flags_ld) begin
                  flags_q <= flags_ld_d;
               end
               if (issue_valid) begin
                  alu_x_q    <= issue_x;
                  alu_y_q    <= issue_y;
                  alu_t_q    <= issue_t;
                  alu_func_q <= issue_func;
                  alu_word_q <= issue_word;
                  alu_seg_q  <= issue_seg;
                  alu_off_q  <= issue_off;
                  fen_q      <= issue_fen;
                  cnt_q      <= cnt_d;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  if (ret_exc_d) begin
                     exc_q <= 1'b1;
                  end else begin
                     res_q <= alu_out;
                     if (fen_q) begin
                        flags_q <= flags_ret_d;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign issue_ready = (state_q == IDLE);
   assign alu_x       = alu_x_q;
   assign alu_y       = alu_y_q;
   assign alu_t       = alu_t_q;
   assign alu_func    = alu_func_q;
   assign alu_word_op = alu_word_q;
   assign alu_seg     = alu_seg_q;
   assign alu_off     = alu_off_q;
   assign alu_iflags  = flags_q;
   assign flags       = flags_q;
   assign res         = res_q;
   assign done        = done_q;
   assign exc         = exc_q;
endmodule
